// File: rtl/audio_tx_byte_packer_pkg.sv
// Shared definitions for the USB audio IN byte packer: subslot codes,
// per-channel byte lookup, FSM encoding and little-endian frame packing.
package audio_tx_byte_packer_pkg;

  localparam logic [1:0] RES_16 = 2'b00;
  localparam logic [1:0] RES_24 = 2'b01;
  localparam logic [1:0] RES_32 = 2'b10;

  localparam int MAX_FB = 8;
  localparam int REM_W  = $clog2(MAX_FB);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic logic [2:0] nb_of(input logic [1:0] res);
    case (res)
      RES_16:  return 3'd2;
      RES_24:  return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  // Byte 0 of the result is the first byte on the wire: left LSB-first, then right.
  function automatic logic [63:0] pack_frame(input logic [31:0] l,
                                             input logic [31:0] r,
                                             input logic [2:0]  nb);
    logic [5:0]  drop_bits;
    logic [31:0] lj;
    logic [31:0] rj;
    drop_bits = 6'd32 - {nb, 3'b000};
    lj = l >> drop_bits;
    rj = r >> drop_bits;
    return {32'd0, lj} | ({32'd0, rj} << {nb, 3'b000});
  endfunction

endpackage

// File: rtl/audio_tx_byte_packer.sv
// Serialises one stereo PCM frame per handshake into USB audio subslot bytes,
// admitting a frame only when the downstream FIFO can hold all of it.
//
// state   | meaning
// IDLE    | s_ready=1, waiting for a frame; space check against fifo_wrnum
// SEND    | emitting frame bytes, one per consumed write
// GAP     | one dead cycle so fifo_wrnum reflects the frame just written
module audio_tx_byte_packer
  import audio_tx_byte_packer_pkg::*;
#(
  parameter int ASIZE  = 9,
  parameter int DROP_W = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [1:0]        cfg_res,
  input  logic              mute,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_left,
  input  logic [31:0]       s_right,
  input  logic [ASIZE:0]    fifo_wrnum,
  input  logic              fifo_full,
  output logic              fifo_write,
  output logic [7:0]        fifo_data,
  output logic              drop_pulse,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [ASIZE:0] DEPTH = {1'b1, {ASIZE{1'b0}}};

  state_e              r_state;
  logic                r_ready;
  logic                r_write;
  logic [7:0]          r_data;
  logic [63:0]         r_buf;
  logic [REM_W-1:0]    r_rem;
  logic                r_drop_pulse;
  logic [DROP_W-1:0]   r_drop_cnt;

  logic [2:0]          w_nb;
  logic [3:0]          w_fb;
  logic [ASIZE:0]      w_free;
  logic                w_fits;
  logic                w_hs;
  logic [63:0]         w_frame;

  assign w_nb    = nb_of(cfg_res);
  assign w_fb    = {w_nb, 1'b0};
  // Occupancy never exceeds DEPTH-1 when not full, so this cannot wrap.
  assign w_free  = DEPTH - fifo_wrnum;
  assign w_fits  = !fifo_full && (w_free >= {{(ASIZE-3){1'b0}}, w_fb});
  assign w_hs    = s_valid && r_ready && (r_state == ST_IDLE);
  assign w_frame = pack_frame(mute ? 32'd0 : s_left, mute ? 32'd0 : s_right, w_nb);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b0;
      r_write      <= 1'b0;
      r_data       <= 8'd0;
      r_buf        <= 64'd0;
      r_rem        <= '0;
      r_drop_pulse <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_drop_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_hs) begin
            if (w_fits) begin
              r_state <= ST_SEND;
              r_ready <= 1'b0;
              r_write <= 1'b1;
              r_data  <= w_frame[7:0];
              r_buf   <= w_frame >> 8;
              r_rem   <= REM_W'(w_fb - 4'd1);
            end else begin
              r_drop_pulse <= 1'b1;
              if (~&r_drop_cnt) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
          end
        end
        ST_SEND: begin
          // A full FIFO leaves the current byte and strobe untouched.
          if (!fifo_full) begin
            if (r_rem != '0) begin
              r_data <= r_buf[7:0];
              r_buf  <= r_buf >> 8;
              r_rem  <= r_rem - REM_W'(1);
            end else begin
              r_write <= 1'b0;
              r_state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready    = r_ready;
  assign fifo_write = r_write;
  assign fifo_data  = r_data;
  assign drop_pulse = r_drop_pulse;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_audio_tx_byte_packer.sv
// Directed self-checking bench for audio_tx_byte_packer; inputs driven and
// outputs sampled on the falling clock edge.
module tb_audio_tx_byte_packer;

  logic        CLK;
  logic        RSTn;
  logic [1:0]  cfg_res;
  logic        mute;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_left;
  logic [31:0] s_right;
  logic [9:0]  fifo_wrnum;
  logic        fifo_full;
  logic        fifo_write;
  logic [7:0]  fifo_data;
  logic        drop_pulse;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int wr_base;

  audio_tx_byte_packer #(.ASIZE(9), .DROP_W(16)) dut (
    .CLK(CLK), .RSTn(RSTn), .cfg_res(cfg_res), .mute(mute),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .fifo_wrnum(fifo_wrnum), .fifo_full(fifo_full), .fifo_write(fifo_write),
    .fifo_data(fifo_data), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) if (fifo_write && !fifo_full) wr_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_hs(input logic [1:0] res, input logic m,
                       input logic [31:0] l, input logic [31:0] r);
    cfg_res = res; mute = m; s_left = l; s_right = r; s_valid = 1'b1;
    @(negedge CLK);
    s_valid = 1'b0;
  endtask

  // exp holds the wire bytes, byte 0 in the low bits.
  task automatic expect_bytes(input string tag, input logic [63:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_wr"}, 32'(fifo_write), 32'd1);
      chk({tag, "_data"}, 32'(fifo_data), 32'(exp[8*i +: 8]));
      @(negedge CLK);
    end
    chk({tag, "_gap_wr"}, 32'(fifo_write), 32'd0);
    chk({tag, "_gap_rdy"}, 32'(s_ready), 32'd0);
    @(negedge CLK);
    chk({tag, "_idle_rdy"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    RSTn = 1'b0; cfg_res = 2'b00; mute = 1'b0; s_valid = 1'b0;
    s_left = 32'd0; s_right = 32'd0; fifo_wrnum = 10'd0; fifo_full = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_write", 32'(fifo_write), 32'd0);
    chk("rst_data", 32'(fifo_data), 32'd0);
    chk("rst_pulse", 32'(drop_pulse), 32'd0);
    chk("rst_cnt", 32'(drop_cnt), 32'd0);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("rel_ready", 32'(s_ready), 32'd1);

    // 24-bit frame into an empty FIFO
    wr_base = wr_count;
    do_hs(2'b01, 1'b0, 32'h112233AA, 32'h445566BB);
    expect_bytes("r24", 64'h0000_4455_6611_2233, 6);
    chk("r24_count", 32'(wr_count - wr_base), 32'd6);

    // muted 16-bit frame, then live 16-bit frame
    do_hs(2'b00, 1'b1, 32'hFFFF0000, 32'h12345678);
    expect_bytes("mute", 64'h0, 4);
    do_hs(2'b00, 1'b0, 32'hABCD1111, 32'h98760000);
    expect_bytes("r16", 64'h0000_0000_9876_ABCD, 4);

    // 32-bit frame with only 4 bytes free: dropped
    fifo_wrnum = 10'd508;
    wr_base = wr_count;
    do_hs(2'b10, 1'b0, 32'h01020304, 32'h05060708);
    chk("drop_pulse", 32'(drop_pulse), 32'd1);
    chk("drop_cnt1", 32'(drop_cnt), 32'd1);
    chk("drop_wr", 32'(fifo_write), 32'd0);
    chk("drop_rdy", 32'(s_ready), 32'd1);
    @(negedge CLK);
    chk("drop_pulse_end", 32'(drop_pulse), 32'd0);
    chk("drop_nowrite", 32'(wr_count - wr_base), 32'd0);

    // exactly 8 bytes free: accepted
    fifo_wrnum = 10'd504;
    wr_base = wr_count;
    do_hs(2'b10, 1'b0, 32'h01020304, 32'h05060708);
    fifo_wrnum = 10'd0;
    expect_bytes("r32", 64'h0506_0708_0102_0304, 8);
    chk("r32_count", 32'(wr_count - wr_base), 32'd8);

    // full FIFO with zero occupancy blocks admission
    fifo_full = 1'b1;
    do_hs(2'b00, 1'b0, 32'h11110000, 32'h22220000);
    fifo_full = 1'b0;
    chk("full_pulse", 32'(drop_pulse), 32'd1);
    chk("full_cnt", 32'(drop_cnt), 32'd2);
    chk("full_wr", 32'(fifo_write), 32'd0);
    @(negedge CLK);

    // stall for 3 cycles while byte index 2 is presented
    wr_base = wr_count;
    do_hs(2'b01, 1'b0, 32'hA1B2C3D4, 32'hE5F60718);
    chk("st_b0", 32'(fifo_data), 32'hC3);
    @(negedge CLK);
    chk("st_b1", 32'(fifo_data), 32'hB2);
    @(negedge CLK);
    chk("st_b2", 32'(fifo_data), 32'hA1);
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("st_hold_wr", 32'(fifo_write), 32'd1);
      chk("st_hold_data", 32'(fifo_data), 32'hA1);
    end
    fifo_full = 1'b0;
    @(negedge CLK);
    expect_bytes("st_tail", 64'h0000_0000_00E5_F607, 3);
    chk("st_count", 32'(wr_count - wr_base), 32'd6);

    // run the drop counter up to 0xFFFE, then saturate
    fifo_wrnum = 10'd508;
    cfg_res = 2'b10;
    s_valid = 1'b1;
    repeat (65532) @(negedge CLK);
    s_valid = 1'b0;
    chk("sat_pre", 32'(drop_cnt), 32'hFFFE);
    s_valid = 1'b1;
    @(negedge CLK);
    chk("sat_cnt1", 32'(drop_cnt), 32'hFFFF);
    chk("sat_pulse1", 32'(drop_pulse), 32'd1);
    @(negedge CLK);
    s_valid = 1'b0;
    chk("sat_cnt2", 32'(drop_cnt), 32'hFFFF);
    chk("sat_pulse2", 32'(drop_pulse), 32'd1);
    @(negedge CLK);
    chk("sat_hold", 32'(drop_cnt), 32'hFFFF);
    fifo_wrnum = 10'd0;

    // reset asserted while the third byte of a 6-byte frame is presented
    do_hs(2'b01, 1'b0, 32'h11223344, 32'h55667788);
    @(negedge CLK);
    @(negedge CLK);
    chk("mid_b2", 32'(fifo_data), 32'h11);
    RSTn = 1'b0;
    #1;
    chk("mid_rst_wr", 32'(fifo_write), 32'd0);
    chk("mid_rst_data", 32'(fifo_data), 32'd0);
    chk("mid_rst_rdy", 32'(s_ready), 32'd0);
    chk("mid_rst_cnt", 32'(drop_cnt), 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("post_rdy", 32'(s_ready), 32'd1);
    chk("post_wr", 32'(fifo_write), 32'd0);
    wr_base = wr_count;
    do_hs(2'b00, 1'b0, 32'hBEEF0000, 32'hCAFE0000);
    expect_bytes("post", 64'h0000_0000_CAFE_BEEF, 4);
    chk("post_count", 32'(wr_count - wr_base), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
